// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter: round-robin arbiter sharing the single combinational read port of the
// instruction memory among NUM_CORES fetch stages. One requester is granted per cycle. The
// granted core's PC is driven to the memory, the returned word is registered, and the word is
// handed back to that core one cycle later with a per-core valid strobe.
//
// Ports:
//   Clk        clock, rising edge
//   Rst        synchronous active-high reset
//   Req        per-core fetch request, held until the matching RespValid bit
//   ReqPC      per-core fetch PC, core k on bits [32k+31:32k]
//   Grant      combinational one-hot (or zero) grant
//   MemAddr    PC of the granted core, 0 when idle
//   MemData    combinational memory read data for MemAddr
//   RespValid  registered per-core response strobe
//   RespInstr  registered instruction, broadcast to all cores
//   RespErr    registered error qualifier for RespInstr
//   Stall      combinational Req & ~RespValid, stalls each core's IF stage
//
// Optional feature: define IMEM_ARB_ALIGN_CHK_EN to turn misaligned or out-of-range PCs
// (PC[1:0] != 0 or PC[31:10] != 0) into a NOP response with RespErr set. The default build
// (macro undefined) always returns MemData with RespErr held at 0.
module imem_fetch_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int PTR_W     = 2
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic [NUM_CORES-1:0]    Req,
  input  logic [32*NUM_CORES-1:0] ReqPC,
  output logic [NUM_CORES-1:0]    Grant,
  output logic [31:0]             MemAddr,
  input  logic [31:0]             MemData,
  output logic [NUM_CORES-1:0]    RespValid,
  output logic [31:0]             RespInstr,
  output logic                    RespErr,
  output logic [NUM_CORES-1:0]    Stall
);

  logic [PTR_W-1:0]     ptr_q;
  logic [NUM_CORES-1:0] resp_valid_q;
  logic [31:0]          resp_instr_q;
  logic                 resp_err_q;

  logic [NUM_CORES-1:0] elig;
  logic [NUM_CORES-1:0] grant;
  logic [PTR_W-1:0]     grant_idx;
  logic [PTR_W-1:0]     scan_idx;
  logic                 grant_any;
  logic [PTR_W-1:0]     ptr_d;
  logic [31:0]          mem_addr;
  logic [31:0]          instr_d;
  logic                 err_d;

  // The pending mask (core granted last cycle) is exactly the response strobe register, so
  // one register serves both roles.
  assign elig = Req & ~resp_valid_q;

  // Scan Ptr, Ptr+1, ... modulo NUM_CORES; the first eligible core wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan_idx  = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      scan_idx = PTR_W'((int'(ptr_q) + i) % NUM_CORES);
      if (!grant_any && elig[scan_idx]) begin
        grant_any       = 1'b1;
        grant_idx       = scan_idx;
        grant[scan_idx] = 1'b1;
      end
    end
  end

  always_comb begin
    mem_addr = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant[i]) begin
        mem_addr = ReqPC[i*32 +: 32];
      end
    end
  end

  assign ptr_d = (grant_idx == PTR_W'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;

`ifdef IMEM_ARB_ALIGN_CHK_EN
  // Bad PCs still reach the memory; only the returned word is replaced by a NOP.
  always_comb begin
    err_d   = (mem_addr[1:0] != 2'b00) || (mem_addr[31:10] != 22'd0);
    instr_d = err_d ? 32'h0000_0000 : MemData;
  end
`else
  always_comb begin
    err_d   = 1'b0;
    instr_d = MemData;
  end
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      ptr_q        <= '0;
      resp_valid_q <= '0;
      resp_instr_q <= '0;
      resp_err_q   <= 1'b0;
    end else if (grant_any) begin
      ptr_q        <= ptr_d;
      resp_valid_q <= grant;
      resp_instr_q <= instr_d;
      resp_err_q   <= err_d;
    end else begin
      // Idle cycle: no strobe, last response word and its qualifier are held.
      resp_valid_q <= '0;
    end
  end

  assign Grant     = grant;
  assign MemAddr   = mem_addr;
  assign RespValid = resp_valid_q;
  assign RespInstr = resp_instr_q;
  assign RespErr   = resp_err_q;
  assign Stall     = Req & ~resp_valid_q;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
module tb_imem_fetch_arbiter;

  localparam int N = 4;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [N-1:0]  Req;
  logic [32*N-1:0] ReqPC;
  logic [N-1:0]  Grant;
  logic [31:0]   MemAddr;
  logic [31:0]   MemData;
  logic [N-1:0]  RespValid;
  logic [31:0]   RespInstr;
  logic          RespErr;
  logic [N-1:0]  Stall;

  logic [31:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          m_ptr;
  int          m_last;   // core granted last cycle, -1 if none
  logic [31:0] m_instr;
  logic        m_err;

  // Observations from the most recent step
  logic [N-1:0] obs_grant, obs_rv;
  logic [31:0]  obs_instr;
  logic         obs_err;

  always #5 Clk = ~Clk;

  assign MemData = mem[MemAddr[9:2]];

  imem_fetch_arbiter #(.NUM_CORES(N), .PTR_W(2)) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .Req       (Req),
    .ReqPC     (ReqPC),
    .Grant     (Grant),
    .MemAddr   (MemAddr),
    .MemData   (MemData),
    .RespValid (RespValid),
    .RespInstr (RespInstr),
    .RespErr   (RespErr),
    .Stall     (Stall)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pc_of(input int k);
    return ReqPC[k*32 +: 32];
  endfunction

  task automatic set_pc(input int k, input logic [31:0] v);
    ReqPC[k*32 +: 32] = v;
  endtask

  // First requesting core at or after the pointer, skipping the one still receiving its word.
  function automatic int model_pick();
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (Req[c] && c != m_last) return c;
    end
    return -1;
  endfunction

  // One clock cycle: compare everything at the falling edge, then advance the model.
  task automatic step();
    int          g;
    logic [N-1:0] eg, erv;
    logic [31:0] ea, pc;
    logic        bad;
    @(negedge Clk);
    g   = model_pick();
    eg  = '0;
    erv = '0;
    ea  = 32'd0;
    if (g >= 0) begin
      eg[g] = 1'b1;
      ea    = pc_of(g);
    end
    if (m_last >= 0) erv[m_last] = 1'b1;
    chk("grant", 32'(Grant), 32'(eg));
    chk("mem_addr", MemAddr, ea);
    chk("resp_valid", 32'(RespValid), 32'(erv));
    chk("resp_instr", RespInstr, m_instr);
    chk("resp_err", 32'(RespErr), 32'(m_err));
    chk("stall", 32'(Stall), 32'(Req & ~erv));
    obs_grant = Grant;
    obs_rv    = RespValid;
    obs_instr = RespInstr;
    obs_err   = RespErr;
    @(posedge Clk);
    if (Rst) begin
      m_ptr = 0; m_last = -1; m_instr = 32'd0; m_err = 1'b0;
    end else if (g >= 0) begin
      pc     = pc_of(g);
      m_ptr  = (g + 1) % N;
      m_last = g;
`ifdef IMEM_ARB_ALIGN_CHK_EN
      bad     = (pc % 4 != 0) || (pc >= 32'd1024);
      m_instr = bad ? 32'd0 : mem[(pc / 4) % 256];
      m_err   = bad;
`else
      bad     = 1'b0;
      m_instr = mem[(pc / 4) % 256];
      m_err   = bad;
`endif
    end else begin
      m_last = -1;
    end
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    Req = '0;
    step();
    Rst = 1'b0;
  endtask

  initial begin
    logic [N-1:0] oh;
    logic [31:0]  exp_instr, exp_err;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[2] = 32'h2010_000A;
    mem[0] = 32'hC0DE_0001;
    Rst   = 1'b1;
    Req   = '0;
    ReqPC = '0;
    m_ptr = 0; m_last = -1; m_instr = 32'd0; m_err = 1'b0;
    #1;
    do_reset();

    // Reset state
    step();
    chk("reset_rv", 32'(obs_rv), 32'd0);
    chk("reset_instr", obs_instr, 32'd0);

    // Single requester: grant every other cycle, word one cycle later
    set_pc(0, 32'h8);
    Req = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i % 2 == 0) chk("single_grant", 32'(obs_grant), 32'h1);
      else begin
        chk("single_gap", 32'(obs_grant), 32'h0);
        chk("single_rv", 32'(obs_rv), 32'h1);
        chk("single_instr", obs_instr, 32'h2010_000A);
      end
    end

    // Full contention from reset: 0,1,2,3,0,... with no gaps
    do_reset();
    for (int k = 0; k < N; k++) set_pc(k, 32'(4 * (k + 16)));
    Req = 4'b1111;
    for (int i = 0; i < 9; i++) begin
      step();
      oh = 4'b0001 << (i % 4);
      chk("rr_order", 32'(obs_grant), 32'(oh));
    end

    // Pointer wrap and skip: bring Ptr to 3, then Req=0101 -> 0, 2, 0
    do_reset();
    Req = 4'b0100;
    step();
    chk("wrap_pre", 32'(obs_grant), 32'h4);
    Req = 4'b0101;
    step(); chk("wrap_a", 32'(obs_grant), 32'h1);
    step(); chk("wrap_b", 32'(obs_grant), 32'h4);
    step(); chk("wrap_c", 32'(obs_grant), 32'h1);

    // Withdrawal: core 2 requests for one cycle while core 0 is granted
    do_reset();
    Req = 4'b0101;
    step();
    chk("wd_grant0", 32'(obs_grant), 32'h1);
    Req = 4'b0001;
    step();
    Req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wd_no_rv2", 32'(obs_rv[2]), 32'h0);
      chk("wd_no_g2", 32'(obs_grant[2]), 32'h0);
    end

    // Reset mid-fetch: the core 1 word granted on a reset edge is never delivered
    do_reset();
    set_pc(0, 32'h8);
    Req = 4'b0001;
    step();
    Req = 4'b0000;
    step();
    chk("rmf_prior_instr", obs_instr, 32'h2010_000A);
    Rst = 1'b1;
    Req = 4'b0010;
    set_pc(1, 32'h40);
    step();
    chk("rmf_grant1", 32'(obs_grant), 32'h2);
    Rst = 1'b0;
    Req = 4'b1111;
    step();
    chk("rmf_rv", 32'(obs_rv), 32'h0);
    chk("rmf_instr", obs_instr, 32'h0);
    chk("rmf_ptr0", 32'(obs_grant), 32'h1);

    // Misaligned / out-of-range PC
    do_reset();
    set_pc(1, 32'h0000_0402);
    Req = 4'b0010;
    step();
    Req = 4'b0000;
    step();
`ifdef IMEM_ARB_ALIGN_CHK_EN
    exp_instr = 32'h0; exp_err = 32'h1;
`else
    exp_instr = 32'hC0DE_0001; exp_err = 32'h0;
`endif
    chk("align_rv", 32'(obs_rv), 32'h2);
    chk("align_instr", obs_instr, exp_instr);
    chk("align_err", 32'(obs_err), exp_err);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) begin
        if (!Req[k]) begin
          if ($urandom_range(0, 7) == 0) set_pc(k, $urandom);
          else set_pc(k, {22'd0, 8'($urandom), 2'b00});
        end
      end
      Req = 4'($urandom);
      Rst = ($urandom_range(0, 49) == 0);
      step();
    end
    Rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_fetch_arbiter.md
Name: imem_fetch_arbiter

Overview:
- Round-robin arbiter that shares the single read port of the instruction memory (256 x 32-bit words, word index = PC[9:2], combinational read) among NUM_CORES fetch stages of the multicore processor.
- Each cycle it picks at most one requesting core, drives that core's PC to the memory, registers the returned word, and returns it to that core one cycle later with a per-core valid strobe.
- Sits between the cores' IF stages and the instruction memory. Cores stall IF while their request is outstanding.

Parameters:
- NUM_CORES, 4, number of requesting cores (2..8).
- PTR_W, 2, width of the round-robin pointer; must equal ceil(log2(NUM_CORES)).

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Rst  input  1  synchronous, active-high reset.
- Req  input  NUM_CORES  per-core fetch request; held high until the matching RespValid bit.
- ReqPC  input  32*NUM_CORES  per-core fetch PC; core k uses bits [32k+31:32k]; held stable while Req[k] is high.
- Grant  output  NUM_CORES  one-hot (or zero) combinational grant for the current cycle.
- MemAddr  output  32  PC of the granted core, 0 when no grant; drives the memory address.
- MemData  input  32  combinational memory read data for MemAddr.
- RespValid  output  NUM_CORES  registered; bit k is high for one cycle when RespInstr belongs to core k.
- RespInstr  output  32  registered instruction, broadcast to all cores.
- RespErr  output  1  registered; qualifies RespInstr as an error response (see Optional Feature).
- Stall  output  NUM_CORES  combinational Req & ~RespValid; drives each core's IF stall.

Behaviour:
- Reset (Rst=1 at an edge): Ptr=0, Pend=0 (no outstanding core), RespValid=0, RespInstr=0, RespErr=0. Any in-flight response is discarded and not delivered after reset.
- Eligibility: Elig = Req & ~PendMask, where PendMask is the one-hot of the core granted in the previous cycle. This prevents a duplicate fetch while that core is still seeing its response.
- Arbitration (combinational): scan cores Ptr, Ptr+1, ... modulo NUM_CORES. The first eligible core is granted. If none is eligible, Grant=0 and MemAddr=0.
- On an edge with a grant to core g:
  - Ptr <= (g+1) mod NUM_CORES.
  - PendMask <= onehot(g).
  - RespInstr <= MemData.
  - RespValid <= onehot(g).
- On an edge with no grant: Ptr is held, PendMask <= 0, RespValid <= 0, RespInstr holds its value.
- Latency: the request is granted in cycle t and the response is valid in cycle t+1. Minimum latency is 1 cycle. A single active core gets at most 1 fetch per 2 cycles.
- Fairness: with all NUM_CORES requesting continuously, each core is granted within NUM_CORES+1 cycles.
- Ptr wrap: from NUM_CORES-1 it returns to 0.
- Simultaneous events:
  - A core deasserting Req in the same cycle as its RespValid is legal.
  - Req rising in the same cycle another core is granted waits for the next scan.
- Req dropped before grant: the request is withdrawn with no side effects.
- Req dropped after grant: the response is still delivered; the core ignores it.
- Unused grant paths for NUM_CORES below 2^PTR_W never assert.

Optional Feature:
- Macro IMEM_ARB_ALIGN_CHK_EN.
- Defined: a granted PC with PC[1:0]!=0 or PC[31:10]!=0 is out of range or misaligned.
  - The arbiter registers RespInstr=32'h0000_0000 (NOP) and RespErr=1 alongside the normal RespValid strobe.
  - Grant and Ptr behave exactly as normal.
  - MemAddr is still driven with the PC.
- Not defined: no checking; RespErr is constant 0 and RespInstr is always MemData.

Test Plan:
- Reset mid-fetch: grant core 1 at t, assert Rst at t+1 -> RespValid=0, RespInstr=0, Ptr=0 after the edge; the core 1 response is never delivered.
- Single requester: Req=4'b0001, PC0=0x08, memory[2]=0x2010000A -> Grant=0001 every other cycle, RespValid[0]=1 with RespInstr=0x2010000A one cycle after each grant, Stall[0]=1 otherwise.
- Full contention: Req=4'b1111 held from reset -> grant order 0,1,2,3,0,... with no gaps; each RespValid one-hot one cycle after its grant.
- Pointer wrap and skip: Ptr=3, Req=4'b0101 -> grant core 0, then core 2, then core 0.
- Withdrawal: Req[2] high for 1 cycle while core 0 is granted, then low -> core 2 is never granted and no RespValid[2] appears.
- IMEM_ARB_ALIGN_CHK_EN defined, PC1=0x0000_0402 -> RespValid[1]=1, RespInstr=0, RespErr=1. With the macro undefined -> RespErr=0 and RespInstr=memory[0].
